// File: rtl/sisc_ctrl_pkg.sv
// Shared encodings for the SISC control unit: FSM states, opcodes, ALU
// operation codes and status-register bit positions.
package sisc_ctrl_pkg;

    typedef enum logic [2:0] {
        S_START0    = 3'd0,
        S_START1    = 3'd1,
        S_FETCH     = 3'd2,
        S_DECODE    = 3'd3,
        S_EXECUTE   = 3'd4,
        S_MEM       = 3'd5,
        S_WRITEBACK = 3'd6,
        S_HALT      = 3'd7
    } state_t;

    localparam logic [3:0] OP_NOP = 4'b0000;
    localparam logic [3:0] OP_ALU = 4'b0001;
    localparam logic [3:0] OP_BRA = 4'b0010;
    localparam logic [3:0] OP_BRR = 4'b0011;
    localparam logic [3:0] OP_LOD = 4'b1000;
    localparam logic [3:0] OP_STR = 4'b1001;
    localparam logic [3:0] OP_HLT = 4'b1111;

    localparam logic [1:0] ALU_PASS  = 2'b00;
    localparam logic [1:0] ALU_ARITH = 2'b01;
    localparam logic [1:0] ALU_ADDR  = 2'b10;

    // Bit positions inside stat = {C,V,N,Z}
    localparam int STAT_Z = 0;
    localparam int STAT_N = 1;
    localparam int STAT_V = 2;
    localparam int STAT_C = 3;

    function automatic logic is_branch(input logic [3:0] op);
        return (op == OP_BRA) || (op == OP_BRR);
    endfunction

endpackage

// File: rtl/sisc_br_cond.sv
// Branch condition evaluator: a branch is taken when any status bit selected
// by the mask is set. An all-zero mask therefore never branches.
module sisc_br_cond
    import sisc_ctrl_pkg::*;
(
    input  logic [3:0] mm,
    input  logic [3:0] stat,
    output logic       taken
);

    assign taken = (mm[STAT_C] & stat[STAT_C]) |
                   (mm[STAT_V] & stat[STAT_V]) |
                   (mm[STAT_N] & stat[STAT_N]) |
                   (mm[STAT_Z] & stat[STAT_Z]);

endmodule

// File: rtl/sisc_ctrl.sv
// Multi-cycle SISC control FSM: START0/START1 warm-up, then a fixed
// FETCH-DECODE-EXECUTE-MEM-WRITEBACK loop, with an absorbing HALT state.
module sisc_ctrl
    import sisc_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] opcode,
    input  logic [3:0] mm,
    input  logic [3:0] stat,
    output logic       ir_load,
    output logic       pc_write,
    output logic       pc_sel,
    output logic       br_sel,
    output logic       rb_sel,
    output logic [1:0] alu_op,
    output logic       stat_en,
    output logic       dm_we,
    output logic       rf_we,
    output logic       wb_sel,
    output logic       halted
);

    state_t state;
    state_t state_nxt;
    logic   taken;

    sisc_br_cond u_br_cond (
        .mm    (mm),
        .stat  (stat),
        .taken (taken)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_START0;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = S_START0;
        case (state)
            S_START0:    state_nxt = S_START1;
            S_START1:    state_nxt = S_FETCH;
            S_FETCH:     state_nxt = S_DECODE;
            S_DECODE:    state_nxt = (opcode == OP_HLT) ? S_HALT : S_EXECUTE;
            S_EXECUTE:   state_nxt = S_MEM;
            S_MEM:       state_nxt = S_WRITEBACK;
            S_WRITEBACK: state_nxt = S_FETCH;
            S_HALT:      state_nxt = S_HALT;
            default:     state_nxt = S_START0;
        endcase
    end

    // Reset gates every strobe so an instruction interrupted by rst commits nothing.
    // opcode/mm are only consulted from DECODE onward, where IR is valid.
    always_comb begin
        ir_load  = 1'b0;
        pc_write = 1'b0;
        pc_sel   = 1'b0;
        br_sel   = 1'b0;
        rb_sel   = 1'b0;
        alu_op   = ALU_PASS;
        stat_en  = 1'b0;
        dm_we    = 1'b0;
        rf_we    = 1'b0;
        wb_sel   = 1'b0;
        halted   = 1'b0;
        if (!rst) begin
            case (state)
                S_FETCH: begin
                    ir_load  = 1'b1;
                    pc_write = 1'b1;
                end
                S_DECODE: begin
                    if (is_branch(opcode) && taken) begin
                        pc_write = 1'b1;
                        pc_sel   = 1'b1;
                        br_sel   = (opcode == OP_BRA);
                    end
                end
                S_EXECUTE: begin
                    case (opcode)
                        OP_ALU: begin
                            alu_op  = ALU_ARITH;
                            stat_en = 1'b1;
                        end
                        OP_LOD: alu_op = ALU_ADDR;
                        OP_STR: begin
                            alu_op = ALU_ADDR;
                            rb_sel = 1'b1;
                        end
                        default: ;
                    endcase
                end
                S_MEM: begin
                    if (opcode == OP_STR) begin
                        dm_we  = 1'b1;
                        rb_sel = 1'b1;
                    end
                end
                S_WRITEBACK: begin
                    case (opcode)
                        OP_ALU: rf_we = 1'b1;
                        OP_LOD: begin
                            rf_we  = 1'b1;
                            wb_sel = 1'b1;
                        end
                        default: ;
                    endcase
                end
                S_HALT:  halted = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sisc_ctrl.sv
// Self-checking bench for sisc_ctrl: per-instruction strobe patterns compared
// against a table-driven reference built from the instruction semantics.
module tb_sisc_ctrl;

    localparam logic [3:0] T_NOP = 4'b0000;
    localparam logic [3:0] T_ALU = 4'b0001;
    localparam logic [3:0] T_BRA = 4'b0010;
    localparam logic [3:0] T_BRR = 4'b0011;
    localparam logic [3:0] T_LOD = 4'b1000;
    localparam logic [3:0] T_STR = 4'b1001;
    localparam logic [3:0] T_HLT = 4'b1111;

    // Bit positions of the packed observation vector
    localparam int B_IR  = 11;
    localparam int B_PCW = 10;
    localparam int B_PCS = 9;
    localparam int B_BRS = 8;
    localparam int B_RB  = 7;
    localparam int B_AL1 = 6;
    localparam int B_AL0 = 5;
    localparam int B_SE  = 4;
    localparam int B_DM  = 3;
    localparam int B_RF  = 2;
    localparam int B_WB  = 1;
    localparam int B_HLT = 0;

    // Phase indices used by the reference: 0..4 = FETCH..WRITEBACK, 5 = HALT
    localparam int PH_FETCH = 0;
    localparam int PH_HALT  = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] opcode;
    logic [3:0] mm;
    logic [3:0] stat;
    logic       ir_load, pc_write, pc_sel, br_sel, rb_sel;
    logic [1:0] alu_op;
    logic       stat_en, dm_we, rf_we, wb_sel, halted;
    logic [11:0] outs;

    int n_tests = 0;
    int n_fail  = 0;
    logic [11:0] obs_v [0:5];
    logic [11:0] exp_q [$];

    sisc_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .opcode   (opcode),
        .mm       (mm),
        .stat     (stat),
        .ir_load  (ir_load),
        .pc_write (pc_write),
        .pc_sel   (pc_sel),
        .br_sel   (br_sel),
        .rb_sel   (rb_sel),
        .alu_op   (alu_op),
        .stat_en  (stat_en),
        .dm_we    (dm_we),
        .rf_we    (rf_we),
        .wb_sel   (wb_sel),
        .halted   (halted)
    );

    assign outs = {ir_load, pc_write, pc_sel, br_sel, rb_sel, alu_op,
                   stat_en, dm_we, rf_we, wb_sel, halted};

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [11:0] model(input int phase, input logic [3:0] op,
                                          input logic [3:0] m, input logic [3:0] s);
        logic [11:0] v;
        bit taken;
        v = '0;
        taken = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (m[i] && s[i]) taken = 1'b1;
        end
        case (phase)
            0: begin
                v[B_IR]  = 1'b1;
                v[B_PCW] = 1'b1;
            end
            1: begin
                if ((op == T_BRA || op == T_BRR) && taken) begin
                    v[B_PCW] = 1'b1;
                    v[B_PCS] = 1'b1;
                    v[B_BRS] = (op == T_BRA);
                end
            end
            2: begin
                if (op == T_ALU) begin
                    v[B_AL0] = 1'b1;
                    v[B_SE]  = 1'b1;
                end else if (op == T_LOD) begin
                    v[B_AL1] = 1'b1;
                end else if (op == T_STR) begin
                    v[B_AL1] = 1'b1;
                    v[B_RB]  = 1'b1;
                end
            end
            3: begin
                if (op == T_STR) begin
                    v[B_DM] = 1'b1;
                    v[B_RB] = 1'b1;
                end
            end
            4: begin
                if (op == T_ALU) begin
                    v[B_RF] = 1'b1;
                end else if (op == T_LOD) begin
                    v[B_RF] = 1'b1;
                    v[B_WB] = 1'b1;
                end
            end
            default: v[B_HLT] = 1'b1;
        endcase
        return v;
    endfunction

    // ---------------- driver tasks ----------------
    // Asserts rst for one edge, releases it, and walks through START0/START1.
    // obs_v[0]: while rst=1, [1]: START0, [2]: START1. Returns inside FETCH.
    task automatic do_reset();
        rst    = 1'b1;
        opcode = 'x;
        mm     = 'x;
        #1 obs_v[0] = outs;
        @(posedge clk);
        #1 rst = 1'b0;
        #1 obs_v[1] = outs;
        @(posedge clk);
        #2 obs_v[2] = outs;
        @(posedge clk);
        #1;
    endtask

    // Starts in FETCH; records each phase into obs_v. Stops after phase stop_at.
    task automatic run_instr(input logic [3:0] op, input logic [3:0] m,
                             input logic [3:0] s, input int stop_at);
        opcode = 'x;
        mm     = 'x;
        stat   = 4'($urandom_range(0, 15));
        #1 obs_v[0] = outs;
        if (stop_at == 0) return;
        @(posedge clk);
        #1 opcode = op;
        mm   = m;
        stat = s;
        #1 obs_v[1] = outs;
        if (stop_at == 1) return;
        if (op == T_HLT) begin
            @(posedge clk);
            #1 stat = 4'($urandom_range(0, 15));
            #1 obs_v[PH_HALT] = outs;
            return;
        end
        for (int p = 2; p <= 4; p++) begin
            @(posedge clk);
            #1 stat = 4'($urandom_range(0, 15));
            #1 obs_v[p] = outs;
            if (stop_at == p) return;
        end
        @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        for (int p = 0; p < 3; p++) begin
            n_tests++;
            if (obs_v[p] !== 12'h000) begin
                n_fail++;
                $display("FAIL reset step %0d: got %03h expected %03h", p, obs_v[p], 12'h000);
            end
        end
        opcode = 'x;
        mm     = 'x;
        #1;
        n_tests++;
        if (outs !== model(PH_FETCH, T_NOP, 4'h0, 4'h0)) begin
            n_fail++;
            $display("FAIL reset first_fetch: got %03h expected %03h",
                     outs, model(PH_FETCH, T_NOP, 4'h0, 4'h0));
        end
    endtask

    task automatic test_alu();
        logic [3:0] m, s;
        m = 4'($urandom_range(0, 15));
        s = 4'($urandom_range(0, 15));
        run_instr(T_ALU, m, s, 5);
        for (int p = 0; p < 5; p++) begin
            n_tests++;
            if (obs_v[p] !== model(p, T_ALU, m, s)) begin
                n_fail++;
                $display("FAIL alu phase %0d: got %03h expected %03h", p, obs_v[p], model(p, T_ALU, m, s));
            end
        end
        opcode = 'x;
        #1;
        n_tests++;
        if (outs !== model(PH_FETCH, T_NOP, 4'h0, 4'h0)) begin
            n_fail++;
            $display("FAIL alu refetch: got %03h expected %03h", outs, model(PH_FETCH, T_NOP, 4'h0, 4'h0));
        end
    endtask

    task automatic test_str_lod();
        logic [3:0] ops [2];
        ops[0] = T_STR;
        ops[1] = T_LOD;
        for (int k = 0; k < 2; k++) begin
            run_instr(ops[k], 4'h0, 4'hF, 5);
            for (int p = 0; p < 5; p++) begin
                n_tests++;
                if (obs_v[p] !== model(p, ops[k], 4'h0, 4'hF)) begin
                    n_fail++;
                    $display("FAIL memop op=%b phase %0d: got %03h expected %03h",
                             ops[k], p, obs_v[p], model(p, ops[k], 4'h0, 4'hF));
                end
            end
        end
    endtask

    task automatic test_branch();
        logic [11:0] cases [6];
        cases[0] = {T_BRA, 4'b0001, 4'b0001};
        cases[1] = {T_BRR, 4'b0100, 4'b1011};
        cases[2] = {T_BRR, 4'b1000, 4'b1000};
        cases[3] = {T_BRA, 4'b0000, 4'b1111};
        cases[4] = {T_BRA, 4'b0110, 4'b1001};
        cases[5] = {T_BRR, 4'b0010, 4'b0011};
        for (int k = 0; k < 6; k++) begin
            run_instr(cases[k][11:8], cases[k][7:4], cases[k][3:0], 5);
            for (int p = 0; p < 5; p++) begin
                n_tests++;
                if (obs_v[p] !== model(p, cases[k][11:8], cases[k][7:4], cases[k][3:0])) begin
                    n_fail++;
                    $display("FAIL branch case %0d phase %0d: got %03h expected %03h", k, p,
                             obs_v[p], model(p, cases[k][11:8], cases[k][7:4], cases[k][3:0]));
                end
            end
        end
    endtask

    task automatic test_random();
        logic [3:0] pool [9];
        logic [3:0] op, m, s;
        logic [11:0] e;
        pool = '{T_NOP, T_ALU, T_BRA, T_BRR, T_LOD, T_STR, 4'b0101, 4'b1100, 4'b1110};
        for (int k = 0; k < 40; k++) begin
            op = pool[$urandom_range(0, 8)];
            m  = 4'($urandom_range(0, 15));
            s  = 4'($urandom_range(0, 15));
            for (int p = 0; p < 5; p++) exp_q.push_back(model(p, op, m, s));
            run_instr(op, m, s, 5);
            for (int p = 0; p < 5; p++) begin
                e = exp_q.pop_front();
                n_tests++;
                if (obs_v[p] !== e) begin
                    n_fail++;
                    $display("FAIL random op=%b mm=%b stat=%b phase %0d: got %03h expected %03h",
                             op, m, s, p, obs_v[p], e);
                end
            end
        end
    endtask

    task automatic test_halt();
        run_instr(T_HLT, 4'hF, 4'hF, 5);
        n_tests++;
        if (obs_v[1] !== model(1, T_HLT, 4'hF, 4'hF)) begin
            n_fail++;
            $display("FAIL halt decode: got %03h expected %03h", obs_v[1], model(1, T_HLT, 4'hF, 4'hF));
        end
        n_tests++;
        if (obs_v[PH_HALT] !== model(PH_HALT, T_HLT, 4'h0, 4'h0)) begin
            n_fail++;
            $display("FAIL halt entry: got %03h expected %03h", obs_v[PH_HALT], model(PH_HALT, T_HLT, 4'h0, 4'h0));
        end
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1 opcode = 4'($urandom_range(0, 15));
            mm   = 4'($urandom_range(0, 15));
            stat = 4'($urandom_range(0, 15));
            #1;
            n_tests++;
            if (outs !== model(PH_HALT, T_HLT, 4'h0, 4'h0)) begin
                n_fail++;
                $display("FAIL halt hold cycle %0d: got %03h expected %03h", c, outs, model(PH_HALT, T_HLT, 4'h0, 4'h0));
            end
        end
        do_reset();
        for (int p = 0; p < 3; p++) begin
            n_tests++;
            if (obs_v[p] !== 12'h000) begin
                n_fail++;
                $display("FAIL halt reset step %0d: got %03h expected %03h", p, obs_v[p], 12'h000);
            end
        end
        run_instr(T_ALU, 4'h0, 4'h0, 5);
        for (int p = 0; p < 5; p++) begin
            n_tests++;
            if (obs_v[p] !== model(p, T_ALU, 4'h0, 4'h0)) begin
                n_fail++;
                $display("FAIL halt resume phase %0d: got %03h expected %03h", p, obs_v[p], model(p, T_ALU, 4'h0, 4'h0));
            end
        end
    endtask

    task automatic test_reset_mid_mem();
        run_instr(T_STR, 4'h3, 4'h1, 3);
        for (int p = 0; p < 4; p++) begin
            n_tests++;
            if (obs_v[p] !== model(p, T_STR, 4'h3, 4'h1)) begin
                n_fail++;
                $display("FAIL midrst str phase %0d: got %03h expected %03h", p, obs_v[p], model(p, T_STR, 4'h3, 4'h1));
            end
        end
        do_reset();
        for (int p = 0; p < 3; p++) begin
            n_tests++;
            if (obs_v[p] !== 12'h000) begin
                n_fail++;
                $display("FAIL midrst step %0d: got %03h expected %03h", p, obs_v[p], 12'h000);
            end
        end
        run_instr(T_LOD, 4'h0, 4'h0, 5);
        for (int p = 0; p < 5; p++) begin
            n_tests++;
            if (obs_v[p] !== model(p, T_LOD, 4'h0, 4'h0)) begin
                n_fail++;
                $display("FAIL midrst lod phase %0d: got %03h expected %03h", p, obs_v[p], model(p, T_LOD, 4'h0, 4'h0));
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        opcode = 'x;
        mm     = 'x;
        stat   = 4'h0;
        test_reset();
        test_alu();
        test_str_lod();
        test_branch();
        test_random();
        test_halt();
        test_reset_mid_mem();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        n_fail++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
